// File: rtl/ama_riscv_branch_resolve.sv
// rtl/ama_riscv_branch_resolve.sv - branch/jump resolution, fetch redirect and flush generation
//
// Purpose:
//   Resolves conditional branches and jumps held by the execute stage, then
//   issues a registered fetch redirect with a one-cycle IF/ID flush. Optional
//   branch statistics counters are enabled by defining AMA_RISCV_BR_STATS_EN.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : execute-stage branch handshake (ready only in IDLE)
//   funct3, is_jal, is_jalr   : instruction decode fields
//   target                    : ALU-computed branch/jump target
//   op_a_eq_b, op_a_lt_b      : comparator results
//   op_uns                    : unsigned-compare select to the comparator
//   redirect_valid / _ready   : fetch redirect handshake
//   redirect_pc               : new fetch PC
//   flush                     : one-cycle kill of younger IF/ID instructions
//   misaligned                : registered redirect target has nonzero [1:0]
//   cnt_br, cnt_taken         : resolved / taken branch counters (0 when stats disabled)

module ama_riscv_branch_resolve #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [31:0]      target,
  input  logic             op_a_eq_b,
  input  logic             op_a_lt_b,
  output logic             op_uns,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             misaligned,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        taken;
  logic        accept;
  logic        take_redirect;
  logic [31:0] eff_target;

  assign op_uns = funct3[1];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = op_a_eq_b;
      3'b001:          taken = !op_a_eq_b;
      3'b100, 3'b110:  taken = op_a_lt_b;
      3'b101, 3'b111:  taken = !op_a_lt_b;
      default:         taken = 1'b0;
    endcase
    // Jumps are unconditional; funct3 is don't-care for them.
    if (is_jal || is_jalr) begin
      taken = 1'b1;
    end
  end

  // JALR clears bit 0 of the computed target.
  assign eff_target = is_jalr ? {target[31:1], 1'b0} : target;

  assign accept        = in_valid && in_ready;
  assign take_redirect = accept && taken;

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (take_redirect) begin
          state_nxt = REDIR;
        end
      end
      REDIR: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect payload only loads on a new taken branch, so it holds through REDIR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= '0;
      misaligned  <= 1'b0;
      flush       <= 1'b0;
    end else begin
      flush <= take_redirect;
      if (take_redirect) begin
        redirect_pc <= eff_target;
        misaligned  <= |eff_target[1:0];
      end
    end
  end

`ifdef AMA_RISCV_BR_STATS_EN
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] taken_q;

  // Saturating counters: stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q    <= '0;
      taken_q <= '0;
    end else begin
      if (accept && !(&br_q)) begin
        br_q <= br_q + CNT_W'(1);
      end
      if (take_redirect && !(&taken_q)) begin
        taken_q <= taken_q + CNT_W'(1);
      end
    end
  end

  assign cnt_br    = br_q;
  assign cnt_taken = taken_q;
`else
  assign cnt_br    = '0;
  assign cnt_taken = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_branch_resolve.sv
// tb/tb_ama_riscv_branch_resolve.sv - self-checking bench for ama_riscv_branch_resolve

module tb_ama_riscv_branch_resolve;

  localparam int CW = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    funct3 = 3'b000;
  logic          is_jal = 1'b0;
  logic          is_jalr = 1'b0;
  logic [31:0]   target = 32'h0;
  logic          op_a_eq_b = 1'b0;
  logic          op_a_lt_b = 1'b0;
  logic          op_uns;
  logic          redirect_valid;
  logic          redirect_ready = 1'b1;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic          misaligned;
  logic [CW-1:0] cnt_br;
  logic [CW-1:0] cnt_taken;

  int n_pass = 0;
  int n_total = 0;

  ama_riscv_branch_resolve #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .funct3         (funct3),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .target         (target),
    .op_a_eq_b      (op_a_eq_b),
    .op_a_lt_b      (op_a_lt_b),
    .op_uns         (op_uns),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misaligned     (misaligned),
    .cnt_br         (cnt_br),
    .cnt_taken      (cnt_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the branch table as the ISA states it.
  function automatic bit ref_taken(input logic [2:0] f3, input logic jal, input logic jalr,
                                   input logic eq, input logic lt);
    if (jal || jalr) return 1'b1;
    case (f3)
      3'd0: return eq;          // BEQ
      3'd1: return !eq;         // BNE
      3'd4: return lt;          // BLT
      3'd5: return !lt;         // BGE
      3'd6: return lt;          // BLTU
      3'd7: return !lt;         // BGEU
      default: return 1'b0;     // reserved encodings never branch
    endcase
  endfunction

  bit          m_busy;
  bit          m_flush;
  logic [31:0] m_pc;
  bit          m_mis;
  int          m_br;
  int          m_tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_flush = 0; m_pc = 0; m_mis = 0; m_br = 0; m_tk = 0;
    end else begin
      m_flush = 0;
      if (m_busy) begin
        if (redirect_ready) m_busy = 0;
      end else if (in_valid) begin
        if (m_br < CMAX) m_br = m_br + 1;
        if (ref_taken(funct3, is_jal, is_jalr, op_a_eq_b, op_a_lt_b)) begin
          if (m_tk < CMAX) m_tk = m_tk + 1;
          m_busy  = 1;
          m_flush = 1;
          m_pc    = is_jalr ? (target - (target % 2)) : target;
          m_mis   = (m_pc % 4) != 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !m_busy);
      check("redirect_valid", redirect_valid, m_busy);
      check("flush", flush, m_flush);
      check("op_uns", op_uns, (funct3 == 3'd2 || funct3 == 3'd3 || funct3 >= 3'd6));
      if (m_busy) begin
        check("redirect_pc", redirect_pc, m_pc);
        check("misaligned", misaligned, m_mis);
      end
`ifdef AMA_RISCV_BR_STATS_EN
      check("cnt_br", cnt_br, m_br);
      check("cnt_taken", cnt_taken, m_tk);
`else
      check("cnt_br", cnt_br, 0);
      check("cnt_taken", cnt_taken, 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic jal, input logic jalr,
                        input logic [31:0] tgt, input logic eq, input logic lt);
    funct3 = f3; is_jal = jal; is_jalr = jalr; target = tgt; op_a_eq_b = eq; op_a_lt_b = lt;
  endtask

  task automatic issue(input logic [2:0] f3, input logic jal, input logic jalr,
                       input logic [31:0] tgt, input logic eq, input logic lt);
    set_br(f3, jal, jalr, tgt, eq, lt);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        jal;
    logic        jalr;
    logic [31:0] tgt;
    logic        eq;
    logic        lt;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[8];

  logic [CW-1:0] exp_sat;

  initial begin
    vecs[0] = '{3'd1, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0};
    vecs[1] = '{3'd1, 1'b0, 1'b0, 32'h0000_0084, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{3'd4, 1'b0, 1'b0, 32'h0000_0C00, 1'b0, 1'b1, 1'b1, 32'h0000_0C00, 1'b0};
    vecs[3] = '{3'd6, 1'b0, 1'b0, 32'h0000_0C04, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[4] = '{3'd5, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
    vecs[5] = '{3'd2, 1'b1, 1'b0, 32'h0000_1002, 1'b0, 1'b0, 1'b1, 32'h0000_1002, 1'b1};
    vecs[6] = '{3'd3, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[7] = '{3'd0, 1'b0, 1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0};

    // Reset state
    step(); step();
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_flush", flush, 1'b0);
    check("rst_misaligned", misaligned, 1'b0);
    check("rst_cnt_br", cnt_br, 0);
    check("rst_cnt_taken", cnt_taken, 0);
    rst_n = 1'b1;

    // BEQ taken, accepted on first edge after reset release
    issue(3'd0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0);
    check("beq_redirect_valid", redirect_valid, 1'b1);
    check("beq_redirect_pc", redirect_pc, 32'h0000_0100);
    check("beq_flush", flush, 1'b1);
    step();
    check("beq_flush_one_cycle", flush, 1'b0);
    check("beq_back_idle", redirect_valid, 1'b0);

    // BGEU not taken
    set_br(3'd7, 1'b0, 1'b0, 32'h0000_0500, 1'b0, 1'b1);
    #1;
    check("bgeu_op_uns", op_uns, 1'b1);
    issue(3'd7, 1'b0, 1'b0, 32'h0000_0500, 1'b0, 1'b1);
    check("bgeu_no_redirect", redirect_valid, 1'b0);
    check("bgeu_no_flush", flush, 1'b0);
    check("bgeu_in_ready", in_ready, 1'b1);

    // JALR misaligned, held redirect, in_valid ignored in REDIR
    redirect_ready = 1'b0;
    issue(3'd0, 1'b0, 1'b1, 32'h0000_0203, 1'b0, 1'b0);
    check("jalr_redirect_pc", redirect_pc, 32'h0000_0202);
    check("jalr_misaligned", misaligned, 1'b1);
    set_br(3'd0, 1'b0, 1'b0, 32'h0000_0400, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_redirect_valid", redirect_valid, 1'b1);
      check("hold_redirect_pc", redirect_pc, 32'h0000_0202);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_no_flush", flush, 1'b0);
    end
    redirect_ready = 1'b1;
    step();
    check("release_idle_gap", redirect_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("held_branch_redirect_pc", redirect_pc, 32'h0000_0400);
    check("held_branch_flush", flush, 1'b1);
    step();

    // Illegal funct3
    issue(3'd2, 1'b0, 1'b0, 32'h0000_0700, 1'b1, 1'b1);
    check("illegal_no_redirect", redirect_valid, 1'b0);
    check("illegal_no_flush", flush, 1'b0);

    // Directed vector table
    foreach (vecs[k]) begin
      issue(vecs[k].f3, vecs[k].jal, vecs[k].jalr, vecs[k].tgt, vecs[k].eq, vecs[k].lt);
      check("vec_redirect_valid", redirect_valid, vecs[k].exp_taken);
      if (vecs[k].exp_taken) begin
        check("vec_redirect_pc", redirect_pc, vecs[k].exp_pc);
        check("vec_misaligned", misaligned, vecs[k].exp_mis);
      end
      step();
    end

    // Reset mid-REDIR
    redirect_ready = 1'b0;
    issue(3'd0, 1'b1, 1'b0, 32'h0000_0900, 1'b0, 1'b0);
    check("pre_reset_redirect_valid", redirect_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_redirect_valid", redirect_valid, 1'b0);
    check("async_rst_redirect_pc", redirect_pc, 32'h0);
    check("async_rst_cnt_br", cnt_br, 0);
    check("async_rst_cnt_taken", cnt_taken, 0);
    check("async_rst_in_ready", in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    issue(3'd0, 1'b0, 1'b0, 32'h0000_0A00, 1'b1, 1'b0);
    check("post_rst_accept", redirect_valid, 1'b1);
    check("post_rst_pc", redirect_pc, 32'h0000_0A00);
    step();

    // Counter saturation: 1 taken so far + 9 not-taken accepts
    for (int i = 0; i < 9; i++) begin
      issue(3'd7, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
`ifdef AMA_RISCV_BR_STATS_EN
    exp_sat = 3'd7;
`else
    exp_sat = 3'd0;
`endif
    check("sat_cnt_br", cnt_br, exp_sat);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ama_riscv_branch_resolve.md
AMA_RISCV_BRANCH_RESOLVE -- requirements
Module: ama_riscv_branch_resolve

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, width of the statistics counters.
REQ-002 The block SHALL have the input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the input rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the input in_valid, 1 bit: the execute stage holds a branch/jump this cycle.
REQ-005 The block SHALL have the output in_ready, 1 bit: the block accepts in_valid this cycle.
REQ-006 The block SHALL have the input funct3, 3 bits: the branch funct3 field.
REQ-007 The block SHALL have the inputs is_jal and is_jalr, 1 bit each: the instruction is an unconditional jump.
REQ-008 The block SHALL have the input target, 32 bits: the ALU-computed branch/jump target.
REQ-009 The block SHALL have the inputs op_a_eq_b and op_a_lt_b, 1 bit each: the branch comparator results.
REQ-010 The block SHALL have the output op_uns, 1 bit: the unsigned-compare select fed to the comparator.
REQ-011 The block SHALL have the output redirect_valid, 1 bit: a fetch redirect is pending.
REQ-012 The block SHALL have the input redirect_ready, 1 bit: fetch accepts the redirect.
REQ-013 The block SHALL have the output redirect_pc, 32 bits: the new fetch PC.
REQ-014 The block SHALL have the output flush, 1 bit: a one-cycle kill of the younger IF/ID instructions.
REQ-015 The block SHALL have the output misaligned, 1 bit: the registered taken target has target[1:0] != 0 after masking.
REQ-016 The block SHALL have the outputs cnt_br and cnt_taken, CNT_W bits each: the resolved-branch and taken-branch counters.

Function
REQ-017 op_uns SHALL be combinational and equal funct3[1].
REQ-018 taken SHALL be computed combinationally as follows.
- 000: eq.
- 001: !eq.
- 100 and 110: lt.
- 101 and 111: !lt.
- 010 and 011: 0.
- is_jal or is_jalr: 1, regardless of funct3.
REQ-019 The effective target SHALL be target with bit0 cleared when is_jalr=1; otherwise it SHALL be target unchanged.
REQ-020 The FSM SHALL have two states, IDLE and REDIR; in_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE with in_valid=1 and taken=1, the FSM SHALL move to REDIR on the next edge, with these registered results:
- redirect_valid=1.
- redirect_pc=effective target.
- misaligned updated.
- flush=1 for exactly that one cycle.
REQ-022 In IDLE with in_valid=1 and taken=0, the FSM SHALL remain in IDLE and SHALL NOT assert redirect_valid or flush.
REQ-023 In REDIR, redirect_valid, redirect_pc and misaligned SHALL hold stable until redirect_ready=1 is sampled; on that edge the FSM SHALL return to IDLE with redirect_valid=0.
REQ-024 Latency from an accepted taken branch to redirect_valid SHALL be exactly 1 cycle; back-to-back redirects SHALL be separated by at least one IDLE cycle.
REQ-025 in_valid presented in REDIR SHALL be ignored (no state, counter or flush effect); upstream SHALL hold it.
REQ-026 redirect_ready while redirect_valid=0 SHALL have no effect.

Reset
REQ-027 Assertion of rst_n=0 SHALL, asynchronously and at any point including mid-REDIR, force:
- state=IDLE.
- redirect_valid=0, redirect_pc=0, flush=0, misaligned=0.
- cnt_br=0, cnt_taken=0.
REQ-028 After rst_n deasserts, the first in_valid SHALL be accepted on the first rising edge.

Configuration
REQ-029 With macro AMA_RISCV_BR_STATS_EN defined, cnt_br SHALL increment on every accepted in_valid, and cnt_taken SHALL increment on every accepted in_valid with taken=1.
REQ-030 With AMA_RISCV_BR_STATS_EN defined, both counters SHALL saturate at all-ones.
REQ-031 Without AMA_RISCV_BR_STATS_EN, the ports cnt_br and cnt_taken SHALL remain present, tied to 0, with no counter flops.

Verification
REQ-032 BEQ: funct3=000, eq=1, target=0x0000_0100, in_valid 1 cycle -> next cycle redirect_valid=1, redirect_pc=0x100, flush=1 for 1 cycle.
REQ-033 BGEU: funct3=111, lt=1 -> op_uns=1, no redirect, no flush, state stays IDLE; cnt_br+1, cnt_taken unchanged (STATS_EN).
REQ-034 JALR: target=0x0000_0203 -> redirect_pc=0x202, misaligned=1.
REQ-035 Hold redirect_ready=0 for 3 cycles, then 1 -> redirect_valid/redirect_pc stable for 4 cycles; in_valid during REDIR ignored; in_ready=0.
REQ-036 Drop rst_n mid-REDIR -> redirect_valid=0 immediately; counters=0; next in_valid accepted.
REQ-037 Illegal funct3=010, eq=1, lt=1 -> no redirect.
